// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency dump sequencer and its snapshot bank.
// Contents: command codes, frame header magic and builder, FSM state encoding,
// and the word-index width helper.
package frequency_analyzer_pkg;

  // Fixed command codes. The dump code is a parameter of the sequencer.
  localparam int CMD_START = 1;
  localparam int CMD_STOP  = 2;
  localparam int CMD_CLEAR = 3;

  localparam logic [15:0] HDR_MAGIC = 16'hFA55;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNAP   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bits needed to address n words. The result is never below 1.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First word of every frame: magic, channel count, sequence number.
  function automatic logic [31:0] make_header(input logic [7:0] ch,
                                              input logic [7:0] seq);
    return {HDR_MAGIC, ch, seq};
  endfunction

endpackage

// File: rtl/frequency_snapshot_bank.sv
// Capture registers for all f1/f2 analyzer results, plus a word-select mux.
// Ports: clk/rst_n (async active-low); capture_i loads every value in one cycle;
//        f1_values_i/f2_values_i are packed inputs with ch0 in the LSBs;
//        rd_idx_i selects a data word (2k = ch k f1, 2k+1 = ch k f2); rd_data_o returns it.
module frequency_snapshot_bank
  import frequency_analyzer_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int VALUE_WIDTH = 32,
  parameter int IDX_W       = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            capture_i,
  input  logic [CHANNELS*VALUE_WIDTH-1:0] f1_values_i,
  input  logic [CHANNELS*VALUE_WIDTH-1:0] f2_values_i,
  input  logic [IDX_W-1:0]                rd_idx_i,
  output logic [VALUE_WIDTH-1:0]          rd_data_o
);

  localparam int NWORDS = 2 * CHANNELS;

  // Stored in frame order so the read side is a plain index.
  logic [VALUE_WIDTH-1:0] snap_q [NWORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NWORDS; k++) begin
        snap_q[k] <= '0;
      end
    end else if (capture_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        snap_q[2*c]   <= f1_values_i[c*VALUE_WIDTH +: VALUE_WIDTH];
        snap_q[2*c+1] <= f2_values_i[c*VALUE_WIDTH +: VALUE_WIDTH];
      end
    end
  end

  // Compare-based mux keeps the index width independent of the array depth.
  // Indices outside the bank read as zero.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (int'(rd_idx_i) == k) begin
        rd_data_o = snap_q[k];
      end
    end
  end

endmodule

// File: rtl/frequency_dump_sequencer.sv
// Command-driven controller for the frequency analyzer bank. It decodes START/STOP/CLEAR/DUMP
// commands, drives the analyzer enable and clear, and streams a coherent snapshot as a framed
// valid/ready word sequence. irq pulses for one cycle when a frame completes.
// Ports: s00_axi_aclk/s00_axi_aresetn (async active-low); cmd_valid/cmd_data/cmd_ready command in;
//        f1_values/f2_values analyzer results; analyzer_enable/analyzer_clear to analyzers;
//        m_valid/m_data/m_last/m_ready stream out; irq, busy, cmd_error status.
// Option: FREQ_DUMP_CHECKSUM_EN appends a word holding the XOR of the header and all data
//         words, and m_last moves onto that word.
module frequency_dump_sequencer
  import frequency_analyzer_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int VALUE_WIDTH = 32,
  parameter int DUMP_CODE   = 666
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic                            cmd_valid,
  input  logic [VALUE_WIDTH-1:0]          cmd_data,
  output logic                            cmd_ready,
  input  logic [CHANNELS*VALUE_WIDTH-1:0] f1_values,
  input  logic [CHANNELS*VALUE_WIDTH-1:0] f2_values,
  output logic                            analyzer_enable,
  output logic                            analyzer_clear,
  output logic                            m_valid,
  output logic [VALUE_WIDTH-1:0]          m_data,
  output logic                            m_last,
  input  logic                            m_ready,
  output logic                            irq,
  output logic                            busy,
  output logic                            cmd_error
);

  localparam int DATA_WORDS = 2 * CHANNELS;
`ifdef FREQ_DUMP_CHECKSUM_EN
  localparam int FRAME_WORDS = DATA_WORDS + 2;
`else
  localparam int FRAME_WORDS = DATA_WORDS + 1;
`endif
  localparam int              IDX_W    = idx_width(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             seq_q, seq_d;
  logic                   en_q, en_d;
  logic                   clr_q, clr_d;
  logic                   err_q, err_d;
  logic                   snap_capture;
  logic                   cmd_fire;
  logic                   xfer;
  logic [VALUE_WIDTH-1:0] header_w;
  logic [VALUE_WIDTH-1:0] bank_w;
  logic [VALUE_WIDTH-1:0] word_w;

  assign cmd_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign cmd_fire        = cmd_valid && cmd_ready;
  assign m_valid         = (state_q == ST_STREAM);
  assign xfer            = m_valid && m_ready;
  assign m_last          = m_valid && (idx_q == LAST_IDX);
  assign irq             = (state_q == ST_DONE);
  assign analyzer_enable = en_q;
  assign analyzer_clear  = clr_q;
  assign cmd_error       = err_q;

  assign header_w = VALUE_WIDTH'(make_header(8'(CHANNELS), seq_q));

  // Frame word k >= 1 maps to bank word k-1. The header slot wraps to an
  // out-of-range index, but the header overrides the bank output there anyway.
  frequency_snapshot_bank #(
    .CHANNELS    (CHANNELS),
    .VALUE_WIDTH (VALUE_WIDTH),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk         (s00_axi_aclk),
    .rst_n       (s00_axi_aresetn),
    .capture_i   (snap_capture),
    .f1_values_i (f1_values),
    .f2_values_i (f2_values),
    .rd_idx_i    (idx_q - IDX_W'(1)),
    .rd_data_o   (bank_w)
  );

`ifdef FREQ_DUMP_CHECKSUM_EN
  logic [VALUE_WIDTH-1:0] csum_q, csum_d;

  // Running XOR of every word already sent in this frame. When the index
  // reaches the checksum slot, it covers the header and all data words.
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_SNAP) begin
      csum_d = '0;
    end else if (xfer) begin
      csum_d = csum_q ^ m_data;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // m_data is a function of registered state only. It therefore holds during a stall,
  // and it reads as zero outside STREAM.
  always_comb begin
    word_w = bank_w;
    if (idx_q == '0) begin
      word_w = header_w;
    end
`ifdef FREQ_DUMP_CHECKSUM_EN
    if (idx_q == LAST_IDX) begin
      word_w = csum_q;
    end
`endif
    m_data = m_valid ? word_w : '0;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    en_d         = en_q;
    clr_d        = 1'b0;
    err_d        = err_q;
    snap_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_data == VALUE_WIDTH'(CMD_START)) begin
            en_d = 1'b1;
          end else if (cmd_data == VALUE_WIDTH'(CMD_STOP)) begin
            en_d = 1'b0;
          end else if (cmd_data == VALUE_WIDTH'(CMD_CLEAR)) begin
            clr_d = 1'b1;
          end else if (cmd_data == VALUE_WIDTH'(DUMP_CODE)) begin
            state_d = ST_SNAP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SNAP: begin
        snap_capture = 1'b1;
        idx_d        = '0;
        state_d      = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        seq_d   = seq_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_frequency_dump_sequencer.sv
// Directed testbench for frequency_dump_sequencer (CHANNELS=3, VALUE_WIDTH=32, DUMP_CODE=666).
// It covers reset state, START/STOP/CLEAR/UNKNOWN, full-rate and stalled dumps, commands
// presented while busy, and a reset mid-frame. It honours FREQ_DUMP_CHECKSUM_EN.
module tb_frequency_dump_sequencer;

  localparam int CH = 3;
  localparam int VW = 32;
`ifdef FREQ_DUMP_CHECKSUM_EN
  localparam int FW = 2 + 2 * CH;
`else
  localparam int FW = 1 + 2 * CH;
`endif

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic [VW-1:0]     cmd_data;
  logic              cmd_ready;
  logic [CH*VW-1:0]  f1_values;
  logic [CH*VW-1:0]  f2_values;
  logic              analyzer_enable;
  logic              analyzer_clear;
  logic              m_valid;
  logic [VW-1:0]     m_data;
  logic              m_last;
  logic              m_ready;
  logic              irq;
  logic              busy;
  logic              cmd_error;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_w [8];

  frequency_dump_sequencer #(
    .CHANNELS    (CH),
    .VALUE_WIDTH (VW),
    .DUMP_CODE   (666)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .f1_values       (f1_values),
    .f2_values       (f2_values),
    .analyzer_enable (analyzer_enable),
    .analyzer_clear  (analyzer_clear),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_last          (m_last),
    .m_ready         (m_ready),
    .irq             (irq),
    .busy            (busy),
    .cmd_error       (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected frame for the snapshot values ch0..2 f1 = 10,20,30 and f2 = 11,22,33.
  task automatic build_frame(input logic [7:0] seq);
    logic [31:0] x;
    exp_w[0] = {16'hFA55, 8'd3, seq};
    exp_w[1] = 32'd10; exp_w[2] = 32'd11;
    exp_w[3] = 32'd20; exp_w[4] = 32'd22;
    exp_w[5] = 32'd30; exp_w[6] = 32'd33;
    x = 32'd0;
    for (int i = 0; i < 7; i++) x = x ^ exp_w[i];
    exp_w[7] = x;
  endtask

  initial begin
    int w;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = '0;
    m_ready = 1'b0;
    f1_values = {32'd30, 32'd20, 32'd10};
    f2_values = {32'd33, 32'd22, 32'd11};
    tick();
    tick();

    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_enable", 32'(analyzer_enable), 32'd0);
    chk("rst_clear", 32'(analyzer_clear), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_error", 32'(cmd_error), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. START then STOP
    cmd_valid = 1'b1; cmd_data = 32'd1;
    chk("start_pre_enable", 32'(analyzer_enable), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("start_enable", 32'(analyzer_enable), 32'd1);
    chk("start_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_data = 32'd2;
    tick();
    cmd_valid = 1'b0;
    chk("stop_enable", 32'(analyzer_enable), 32'd0);
    chk("stop_cmd_ready", 32'(cmd_ready), 32'd1);

    // 2. CLEAR pulse, unknown command, sticky error
    cmd_valid = 1'b1; cmd_data = 32'd3;
    tick();
    cmd_valid = 1'b0;
    chk("clear_pulse", 32'(analyzer_clear), 32'd1);
    tick();
    chk("clear_gone", 32'(analyzer_clear), 32'd0);
    chk("clear_no_err", 32'(cmd_error), 32'd0);
    cmd_valid = 1'b1; cmd_data = 32'd7;
    tick();
    cmd_valid = 1'b0;
    chk("unknown_err", 32'(cmd_error), 32'd1);
    chk("unknown_enable", 32'(analyzer_enable), 32'd0);
    cmd_valid = 1'b1; cmd_data = 32'd1;
    tick();
    cmd_valid = 1'b0;
    chk("err_sticky", 32'(cmd_error), 32'd1);
    chk("start2_enable", 32'(analyzer_enable), 32'd1);

    // 3. Full-rate dump
    build_frame(8'd0);
    m_ready = 1'b1;
    cmd_valid = 1'b1; cmd_data = 32'd666;
    tick();
    cmd_valid = 1'b0;
    chk("snap_busy", 32'(busy), 32'd1);
    chk("snap_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("snap_m_valid", 32'(m_valid), 32'd0);
    tick();
    for (int i = 0; i < FW; i++) begin
      chk("d1_valid", 32'(m_valid), 32'd1);
      chk("d1_data", m_data, exp_w[i]);
      chk("d1_last", 32'(m_last), 32'(i == FW - 1));
      chk("d1_irq_low", 32'(irq), 32'd0);
      tick();
    end
    chk("d1_valid_drop", 32'(m_valid), 32'd0);
    chk("d1_irq", 32'(irq), 32'd1);
    chk("d1_enable_kept", 32'(analyzer_enable), 32'd1);
    tick();
    chk("d1_irq_once", 32'(irq), 32'd0);
    chk("d1_idle", 32'(cmd_ready), 32'd1);

    // 4. Stalled dump with inputs changing after the snapshot
    build_frame(8'd1);
    m_ready = 1'b0;
    cmd_valid = 1'b1; cmd_data = 32'd666;
    tick();
    cmd_valid = 1'b0;
    tick();
    f1_values = {32'd99, 32'd98, 32'd97};
    f2_values = {32'd96, 32'd95, 32'd94};
    w = 0;
    for (int c = 0; c < 4 * FW && w < FW; c++) begin
      m_ready = (c % 2 == 1);
      chk("d2_valid", 32'(m_valid), 32'd1);
      chk("d2_data", m_data, exp_w[w]);
      chk("d2_last", 32'(m_last), 32'(w == FW - 1));
      tick();
      if (m_ready) w++;
    end
    chk("d2_word_count", 32'(w), 32'(FW));
    m_ready = 1'b0;
    chk("d2_irq", 32'(irq), 32'd1);
    chk("d2_valid_drop", 32'(m_valid), 32'd0);
    tick();
    chk("d2_irq_once", 32'(irq), 32'd0);

    // 5. Commands ignored while busy, then a reset mid-frame
    f1_values = {32'd30, 32'd20, 32'd10};
    f2_values = {32'd33, 32'd22, 32'd11};
    m_ready = 1'b1;
    cmd_valid = 1'b1; cmd_data = 32'd666;
    tick();
    cmd_data = 32'd2;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("busy_stop_ignored", 32'(analyzer_enable), 32'd1);
    chk("busy_still_stream", 32'(m_valid), 32'd1);
    chk("busy_word3", m_data, 32'd20);
    rst_n = 1'b0;
    #1;
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_m_last", 32'(m_last), 32'd0);
    chk("abort_irq", 32'(irq), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("abort_irq_later", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick();

    // After reset, seq restarts at zero.
    build_frame(8'd0);
    m_ready = 1'b0;
    cmd_valid = 1'b1; cmd_data = 32'd666;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_header", m_data, exp_w[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
